mcs_bridge_ws: RTL and testbench

Parametrised MicroBlaze MCS IO-bus to FPro-bus bridge with wait states. It sits between the `cpu` IO port and the FPro slave subsystems (mmio, video, and further regions). It decodes the bridge window into N regions and registers every transfer. Each transfer gets a programmable read latency, per-region ready handshake and a timeout with error reporting. It replaces the zero-wait, always-ready bridge used so far.

---
 rtl/mcs_bridge_pkg.sv | 25 ++
 rtl/mcs_region_dec.sv | 46 ++++
 rtl/mcs_bridge_ws.sv | 188 ++++++++++++++++++
 tb/tb_mcs_bridge_ws.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcs_bridge_pkg
//  Description : Shared types and constants for the MCS IO-bus to FPro-bus
//                bridge with wait states.
//  Revision    : 1.0  initial release
// ============================================================================
package mcs_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } bridge_state_t;

    // Read data returned when a transfer is aborted by the timeout
    localparam logic [31:0] ERR_RD_DATA = 32'hFFFF_FFFF;
    // FPro word address width, taken from io_address[22:2]
    localparam int FP_ADDR_W  = 21;
    // Most significant address bit of the region index field
    localparam int REGION_MSB = 23;

endpackage
`default_nettype wire

// File: rtl/mcs_region_dec.sv
`default_nettype none
// ============================================================================
//  Module      : mcs_region_dec
//  Description : Combinational bridge-window hit detect and one-hot region
//                decode of an MCS IO address.
//  Ports       : i_address  MCS IO address
//                o_hit      address lies in the bridge window (bits [31:24])
//                o_sel      one-hot region select
//  Revision    : 1.0  initial release
// ============================================================================
module mcs_region_dec
    import mcs_bridge_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int          N_REGION = 2
) (
    input  logic [31:0]         i_address,
    output logic                o_hit,
    output logic [N_REGION-1:0] o_sel
);

    assign o_hit = (i_address[31:24] == BRG_BASE[31:24]);

    generate
        if (N_REGION > 1) begin : g_multi
            localparam int c_IDX_W = $clog2(N_REGION);
            logic [c_IDX_W-1:0] w_idx;
            logic               w_unused_lo;

            assign w_idx       = i_address[REGION_MSB -: c_IDX_W];
            assign w_unused_lo = ^i_address[REGION_MSB-c_IDX_W:0];

            always_comb begin
                o_sel        = '0;
                o_sel[w_idx] = 1'b1;
            end
        end else begin : g_single
            logic w_unused_lo;

            assign w_unused_lo = ^i_address[REGION_MSB:0];
            assign o_sel       = '1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mcs_bridge_ws.sv
`default_nettype none
// ============================================================================
//  Module      : mcs_bridge_ws
//  Description : MicroBlaze MCS IO-bus to FPro-bus bridge with programmable
//                read latency, per-region ready handshake and timeout.
//  Ports       : clk, reset_n (async, active-low)
//                io_*   MCS IO bus (strobes, address, data, byte enables,
//                       registered read data, one-cycle io_ready pulse)
//                fp_*   FPro bus (one-hot cs, rd/wr strobes, word address,
//                       write data, byte enables, per-region rd data/ready)
//                busy     high whenever the bridge is not idle
//                err_cnt  saturating count of window misses and timeouts
//  Revision    : 1.0  initial release
// ============================================================================
module mcs_bridge_ws
    import mcs_bridge_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int          N_REGION = 2,
    parameter int          RD_LAT   = 1,
    parameter int          TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     io_addr_strobe,
    input  logic                     io_read_strobe,
    input  logic                     io_write_strobe,
    input  logic [3:0]               io_byte_enable,
    input  logic [31:0]              io_address,
    input  logic [31:0]              io_write_data,
    output logic [31:0]              io_read_data,
    output logic                     io_ready,
    output logic [N_REGION-1:0]      fp_cs,
    output logic                     fp_wr,
    output logic                     fp_rd,
    output logic [FP_ADDR_W-1:0]     fp_addr,
    output logic [31:0]              fp_wr_data,
    output logic [3:0]               fp_be,
    input  logic [32*N_REGION-1:0]   fp_rd_data,
    input  logic [N_REGION-1:0]      fp_ready,
    output logic                     busy,
    output logic [7:0]               err_cnt
);

    localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAT  = c_CNT_W'(RD_LAT);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    bridge_state_t          r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_we;
    logic [N_REGION-1:0]    r_sel;
    logic [31:0]            r_rd_data;
    logic                   r_ready;
    logic [N_REGION-1:0]    r_cs;
    logic                   r_fp_wr;
    logic                   r_fp_rd;
    logic [FP_ADDR_W-1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [3:0]             r_be;
    logic                   r_busy;
    logic [7:0]             r_err_cnt;

    logic                   w_hit;
    logic [N_REGION-1:0]    w_sel;
    logic                   w_start;
    logic                   w_rdy;
    logic                   w_done;
    logic                   w_timeout;
    logic [31:0]            w_rd_slice;

    mcs_region_dec #(
        .BRG_BASE (BRG_BASE),
        .N_REGION (N_REGION)
    ) u_dec (
        .i_address (io_address),
        .o_hit     (w_hit),
        .o_sel     (w_sel)
    );

    // A read and a write strobe together are handled as a write
    assign w_start   = io_addr_strobe && (io_read_strobe || io_write_strobe);
    assign w_rdy     = |(fp_ready & r_sel);
    assign w_done    = w_rdy && (r_we || (r_cnt >= c_RD_LAT));
    assign w_timeout = (r_cnt == c_TIMEOUT);

    always_comb begin
        w_rd_slice = '0;
        for (int i = 0; i < N_REGION; i++) begin
            if (r_sel[i]) begin
                w_rd_slice = fp_rd_data[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_rd_data <= '0;
            r_ready   <= 1'b0;
            r_cs      <= '0;
            r_fp_wr   <= 1'b0;
            r_fp_rd   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_busy    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr  <= io_address[FP_ADDR_W+1:2];
                        r_wdata <= io_write_data;
                        r_be    <= io_byte_enable;
                        r_we    <= io_write_strobe;
                        r_sel   <= w_sel;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (w_hit) begin
                            r_state <= ST_ACCESS;
                            r_cs    <= w_sel;
                            r_fp_wr <= io_write_strobe;
                            r_fp_rd <= !io_write_strobe;
                        end else begin
                            // Window miss: complete immediately, no FPro cycle
                            r_state   <= ST_DONE;
                            r_ready   <= 1'b1;
                            r_rd_data <= '0;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                        end
                    end
                end
                ST_ACCESS, ST_WAIT: begin
                    // Strobes are single-cycle; cs stays up while waiting
                    r_fp_wr <= 1'b0;
                    r_fp_rd <= 1'b0;
                    if (w_done) begin
                        if (!r_we) begin
                            r_rd_data <= w_rd_slice;
                        end
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                        r_cs    <= '0;
                    end else if (w_timeout) begin
                        r_rd_data <= ERR_RD_DATA;
                        r_state   <= ST_DONE;
                        r_ready   <= 1'b1;
                        r_cs      <= '0;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_read_data = r_rd_data;
    assign io_ready     = r_ready;
    assign fp_cs        = r_cs;
    assign fp_wr        = r_fp_wr;
    assign fp_rd        = r_fp_rd;
    assign fp_addr      = r_addr;
    assign fp_wr_data   = r_wdata;
    assign fp_be        = r_be;
    assign busy         = r_busy;
    assign err_cnt      = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mcs_bridge_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcs_bridge_ws
//  Description : Self-checking bench for mcs_bridge_ws (N_REGION=2,
//                RD_LAT=3, TIMEOUT=20): directed vector table, randomized
//                transfers against a latency/data model, err_cnt saturation
//                and reset during a wait.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcs_bridge_ws;

    localparam int RD_LAT  = 3;
    localparam int TIMEOUT = 20;
    localparam int STUCK   = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address, io_write_data, io_read_data;
    logic        io_ready;
    logic [1:0]  fp_cs;
    logic        fp_wr, fp_rd;
    logic [20:0] fp_addr;
    logic [31:0] fp_wr_data;
    logic [3:0]  fp_be;
    logic [63:0] fp_rd_data;
    logic [1:0]  fp_ready;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] m_last;
    int          m_err;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        bit          rd;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;     // cycles fp_ready[r] stays low after ACCESS starts
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          exp_lat;   // cycles from strobe cycle to io_ready
        logic [31:0] exp_data;
        int          exp_err;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    mcs_bridge_ws #(
        .BRG_BASE (32'hC000_0000),
        .N_REGION (2),
        .RD_LAT   (RD_LAT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .fp_cs           (fp_cs),
        .fp_wr           (fp_wr),
        .fp_rd           (fp_rd),
        .fp_addr         (fp_addr),
        .fp_wr_data      (fp_wr_data),
        .fp_be           (fp_be),
        .fp_rd_data      (fp_rd_data),
        .fp_ready        (fp_ready),
        .busy            (busy),
        .err_cnt         (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Expected latency/data/err_cnt from the transfer rules
    task automatic model_fill(inout vec_t v);
        int j;
        if (v.addr[31:24] != 8'hC0) begin
            v.exp_lat  = 1;
            v.exp_data = 32'h0;
            if (m_err < 255) m_err++;
        end else begin
            j = v.delay;
            if (!v.we && RD_LAT > j) j = RD_LAT;
            if (j > TIMEOUT) begin
                v.exp_lat  = TIMEOUT + 2;
                v.exp_data = 32'hFFFF_FFFF;
                if (m_err < 255) m_err++;
            end else begin
                v.exp_lat  = j + 2;
                v.exp_data = v.we ? m_last : (v.addr[23] ? v.rd1 : v.rd0);
            end
        end
        m_last    = v.exp_data;
        v.exp_err = m_err;
    endtask

    task automatic run_xfer(input vec_t v);
        bit         miss;
        bit         r1;
        bit         rdy;
        logic [1:0] ecs;
        int         lat;
        miss = (v.addr[31:24] != 8'hC0);
        r1   = v.addr[23];
        ecs  = miss ? 2'b00 : (r1 ? 2'b10 : 2'b01);
        @(negedge clk);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = v.rd;
        io_write_strobe = v.we;
        io_address      = v.addr;
        io_write_data   = v.wdata;
        io_byte_enable  = v.be;
        fp_rd_data      = {v.rd1, v.rd0};
        @(posedge clk);
        #1;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_address      = $urandom;
        io_write_data   = $urandom;
        io_byte_enable  = 4'($urandom);
        lat = -1;
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            @(negedge clk);
            rdy      = ((k - 1) >= v.delay);
            fp_ready = r1 ? {rdy, ~rdy} : {~rdy, rdy};
            if (k == 1) begin
                chk("fp_cs", 32'(fp_cs), 32'(ecs));
                chk("fp_wr", 32'(fp_wr), 32'(!miss && v.we));
                chk("fp_rd", 32'(fp_rd), 32'(!miss && !v.we));
                chk("busy_active", 32'(busy), 32'd1);
                if (!miss) begin
                    chk("fp_addr", 32'(fp_addr), 32'(v.addr[22:2]));
                    chk("fp_be", 32'(fp_be), 32'(v.be));
                    if (v.we) chk("fp_wr_data", fp_wr_data, v.wdata);
                end
            end
            if (k == 2 && !miss) chk("strobe_one_cycle", 32'(fp_wr | fp_rd), 32'd0);
            if (io_ready) begin
                lat = k;
                if (!miss) chk("fp_addr_held", 32'(fp_addr), 32'(v.addr[22:2]));
                break;
            end
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("rd_data", io_read_data, v.exp_data);
        chk("err_cnt", 32'(err_cnt), 32'(v.exp_err));
        @(negedge clk);
        chk("ready_pulse", 32'(io_ready), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t v;
        bit   seen;
        int   mode;

        tbl[0] = '{32'hC000_0010, 1, 0, 32'h1234_5678, 4'hF, 0,     32'h0BAD_0000, 32'hA5A5_0001, 2,  32'h0000_0000, 0};
        tbl[1] = '{32'hC080_0008, 0, 1, 32'h0,         4'hF, 0,     32'h0BAD_0000, 32'hA5A5_0001, 5,  32'hA5A5_0001, 0};
        tbl[2] = '{32'hC000_0004, 0, 1, 32'h0,         4'hF, 10,    32'h0BAD_0000, 32'hA5A5_0001, 12, 32'h0BAD_0000, 0};
        tbl[3] = '{32'hC000_0000, 0, 1, 32'h0,         4'hF, STUCK, 32'h0BAD_0000, 32'hA5A5_0001, 22, 32'hFFFF_FFFF, 1};
        tbl[4] = '{32'h8000_0000, 0, 1, 32'h0,         4'hF, 0,     32'h0BAD_0000, 32'hA5A5_0001, 1,  32'h0000_0000, 2};
        tbl[5] = '{32'hC080_00FC, 1, 1, 32'hDEAD_BEEF, 4'h3, 0,     32'h0BAD_0000, 32'hA5A5_0001, 2,  32'h0000_0000, 2};
        tbl[6] = '{32'hC000_0020, 1, 0, 32'h55AA_33CC, 4'hC, 5,     32'h0BAD_0000, 32'hA5A5_0001, 7,  32'h0000_0000, 2};
        tbl[7] = '{32'hC080_0000, 0, 1, 32'h0,         4'hF, 2,     32'h0BAD_0000, 32'hA5A5_0001, 5,  32'hA5A5_0001, 2};
        tbl[8] = '{32'hC000_0040, 1, 0, 32'h0102_0304, 4'h1, STUCK, 32'h0BAD_0000, 32'hA5A5_0001, 22, 32'hFFFF_FFFF, 3};
        tbl[9] = '{32'h0000_0000, 1, 0, 32'h0,         4'hF, 0,     32'h0BAD_0000, 32'hA5A5_0001, 1,  32'h0000_0000, 4};

        reset_n         = 1'b0;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_byte_enable  = 4'h0;
        io_address      = 32'h0;
        io_write_data   = 32'h0;
        fp_rd_data      = 64'h0;
        fp_ready        = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_io_ready", 32'(io_ready), 32'd0);
        chk("rst_fp_cs", 32'(fp_cs), 32'd0);
        chk("rst_fp_wr", 32'(fp_wr), 32'd0);
        chk("rst_fp_rd", 32'(fp_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_data", io_read_data, 32'd0);
        chk("rst_fp_addr", 32'(fp_addr), 32'd0);
        chk("rst_fp_wr_data", fp_wr_data, 32'd0);
        chk("rst_fp_be", 32'(fp_be), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) run_xfer(tbl[i]);
        m_last = tbl[9].exp_data;
        m_err  = tbl[9].exp_err;

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                v.addr = $urandom;
                if (v.addr[31:24] == 8'hC0) v.addr[31:24] = 8'h00;
            end else begin
                v.addr = {8'hC0, 24'($urandom)};
            end
            mode    = $urandom_range(0, 2);
            v.we    = (mode != 0);
            v.rd    = (mode != 1);
            v.wdata = $urandom;
            v.be    = 4'($urandom);
            v.delay = ($urandom_range(0, 9) == 0) ? STUCK : $urandom_range(0, 6);
            v.rd0   = $urandom;
            v.rd1   = $urandom;
            model_fill(v);
            run_xfer(v);
        end

        // err_cnt saturation over 300 misses
        for (int i = 0; i < 300; i++) begin
            v.addr  = {8'h80, 24'($urandom)};
            v.we    = 1'b0;
            v.rd    = 1'b1;
            v.wdata = 32'h0;
            v.be    = 4'hF;
            v.delay = 0;
            v.rd0   = $urandom;
            v.rd1   = $urandom;
            model_fill(v);
            run_xfer(v);
        end
        chk("err_saturated", 32'(err_cnt), 32'd255);

        // Reset asserted while waiting on a stuck slave
        @(negedge clk);
        io_addr_strobe = 1'b1;
        io_read_strobe = 1'b1;
        io_address     = 32'hC000_0008;
        fp_ready       = 2'b00;
        @(posedge clk);
        #1;
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        repeat (5) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fp_cs", 32'(fp_cs), 32'd0);
        chk("mid_rst_fp_rd", 32'(fp_rd), 32'd0);
        chk("mid_rst_fp_wr", 32'(fp_wr), 32'd0);
        chk("mid_rst_io_ready", 32'(io_ready), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (io_ready) seen = 1'b1;
        end
        chk("no_ready_after_rst", 32'(seen), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);
        m_last = 32'h0;
        m_err  = 0;

        // Normal traffic after the reset
        v = '{32'hC080_0010, 0, 1, 32'h0, 4'hF, 0, 32'h1111_2222, 32'h3333_4444, 0, 32'h0, 0};
        model_fill(v);
        run_xfer(v);
        v = '{32'hC000_0014, 1, 0, 32'hCAFE_F00D, 4'h6, 1, 32'h0, 32'h0, 0, 32'h0, 0};
        model_fill(v);
        run_xfer(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
